// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared widths and defaults for the register-file writeback controller.
package regfile_wb_ctrl_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int XLEN          = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// In-order FIFO of destination-register tags for loads outstanding in the cache.
// Exposes every slot with a valid bit so the parent can compare against all pending tags.
module wb_tag_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                push,
    input  logic [REG_ADDR_W-1:0]               push_tag,
    input  logic                                pop,
    output logic [REG_ADDR_W-1:0]               head_tag,
    output logic [CW-1:0]                       count,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]         rd_ptr_reg;
    logic [PW-1:0]         wr_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [REG_ADDR_W-1:0] tag_mem [DEPTH];

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Tag storage needs no reset: slots outside the valid window are masked.
    always_ff @(posedge CLK) begin
        if (push)
            tag_mem[wr_ptr_reg] <= push_tag;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offs;
            assign offs            = PW'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = (CW'(offs) < count_reg);
            assign entry_tag[gi]   = tag_mem[gi];
        end
    endgenerate

    assign head_tag = tag_mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter: load returns beat ALU results, ALU writes to a
// register with a load in flight are held off, and the chosen write is registered.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    output logic                  ld_issue_ready,
    input  logic                  ld_ret_valid,
    input  logic [XLEN-1:0]       ld_ret_data,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]       WD3,
    output logic                  WE3,
    output logic                  err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [REG_ADDR_W-1:0]            head_tag;
    logic [CW-1:0]                    count;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_tag;
    logic [DEPTH-1:0]                 match1;
    logic [DEPTH-1:0]                 match2;
    logic [DEPTH-1:0]                 match_alu;

    logic    q_full;
    logic    q_empty;
    logic    do_pop;
    logic    do_push;
    logic    alu_acc;
    wb_req_t wb_next;

    wb_tag_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push        (do_push),
        .push_tag    (ld_issue_rd),
        .pop         (do_pop),
        .head_tag    (head_tag),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_tag   (entry_tag)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match1[gi]    = entry_valid[gi] && (entry_tag[gi] == rs1);
            assign match2[gi]    = entry_valid[gi] && (entry_tag[gi] == rs2);
            assign match_alu[gi] = entry_valid[gi] && (entry_tag[gi] == alu_rd);
        end
    endgenerate

    assign busy1 = (|match1) && (rs1 != '0);
    assign busy2 = (|match2) && (rs2 != '0);

    assign q_full         = (count == CW'(DEPTH));
    assign q_empty        = (count == '0);
    assign ld_issue_ready = (count < CW'(DEPTH));

    // A full queue can still take an issue when the head retires in the same cycle.
    assign do_pop    = ld_ret_valid && !q_empty;
    assign do_push   = ld_issue && (!q_full || do_pop);
    assign alu_ready = !ld_ret_valid && !(|match_alu);
    assign alu_acc   = alu_valid && alu_ready;

    always_comb begin
        wb_next.rd   = alu_rd;
        wb_next.data = alu_data;
        if (do_pop) begin
            wb_next.rd   = head_tag;
            wb_next.data = ld_ret_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
            err <= 1'b0;
        end else begin
            WE3 <= 1'b0;
            if (do_pop || alu_acc) begin
                A3  <= wb_next.rd;
                WD3 <= wb_next.data;
                WE3 <= (wb_next.rd != '0);
            end
            if ((ld_issue && q_full && !do_pop) || (ld_ret_valid && q_empty))
                err <= 1'b1;
        end
    end

endmodule
